// File: rtl/dma_rd_channel.sv
// DMA read channel, host side.
// Turns an AFU transfer (byte address + line count) into in-order cache-line
// read requests and buffers the responses in a first-word-fall-through FIFO.
// Requests are only issued while (outstanding + buffered) < FIFO_DEPTH, so a
// response always has a free slot waiting for it.
module dma_rd_channel #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int CL_OFFSET  = 6,
    parameter int SIZE_WIDTH = 43,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_go,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [SIZE_WIDTH-1:0]          rd_size,
    input  logic                           rd_en,
    output logic                           empty,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_done,
    output logic                           mem_req_valid,
    output logic [ADDR_WIDTH-CL_OFFSET-1:0] mem_req_addr,
    input  logic                           mem_req_ready,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          mem_rsp_data
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = ADDR_WIDTH - CL_OFFSET;

    // state  | meaning
    // IDLE   | after reset, waiting for rd_go
    // ACTIVE | issuing requests / buffering responses until the last pop
    // DONE   | every line consumed, rd_done high, waiting for rd_go
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                 state;
    logic [SIZE_WIDTH-1:0]  req_left;
    logic [SIZE_WIDTH-1:0]  pop_left;
    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       fifo_count;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];

    logic                   go_ok;
    logic                   req_acc;
    logic                   push;
    logic                   pop;
    logic                   last_pop;
    logic [SIZE_WIDTH-1:0]  req_left_nxt;
    logic [CNT_W-1:0]       outstanding_nxt;
    logic [CNT_W-1:0]       fifo_count_nxt;
    logic [CNT_W:0]         credit_used;
    logic [PTR_W-1:0]       rd_ptr_nxt;
    logic [DATA_WIDTH-1:0]  head_nxt;

    // Byte offset within a line is irrelevant: requests are whole lines.
    logic unused_addr_bits;
    assign unused_addr_bits = ^rd_addr[CL_OFFSET-1:0];

    // Handshake qualifiers and next-cycle counter values shared by the FSM.
    always_comb begin
        go_ok           = rd_go && (state != ACTIVE);
        req_acc         = mem_req_valid && mem_req_ready;
        push            = mem_rsp_valid && (state == ACTIVE);
        pop             = rd_en && !empty;
        last_pop        = pop && (pop_left == SIZE_WIDTH'(1));
        req_left_nxt    = req_left - SIZE_WIDTH'(req_acc);
        outstanding_nxt = outstanding + CNT_W'(req_acc) - CNT_W'(push);
        fifo_count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);
        credit_used     = {1'b0, outstanding_nxt} + {1'b0, fifo_count_nxt};
        rd_ptr_nxt      = rd_ptr + PTR_W'(pop);
        // The incoming line becomes the head when nothing older survives.
        if ((fifo_count == CNT_W'(0)) || (pop && (fifo_count == CNT_W'(1))))
            head_nxt = mem_rsp_data;
        else
            head_nxt = fifo_mem[rd_ptr_nxt];
    end

    // Response storage; no reset needed, validity tracked by fifo_count.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_rsp_data;
    end

    // Transfer FSM with registered request, head-of-FIFO and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_left      <= '0;
            pop_left      <= '0;
            outstanding   <= '0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            empty         <= 1'b1;
            rd_data       <= '0;
            rd_done       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go_ok) begin
                        req_left      <= rd_size;
                        pop_left      <= rd_size;
                        mem_req_addr  <= rd_addr[ADDR_WIDTH-1:CL_OFFSET];
                        mem_req_valid <= (rd_size != '0);
                        rd_done       <= (rd_size == '0);
                        state         <= (rd_size != '0) ? ACTIVE : DONE;
                    end
                end
                ACTIVE: begin
                    req_left     <= req_left_nxt;
                    mem_req_addr <= mem_req_addr + LINE_W'(req_acc);
                    outstanding  <= outstanding_nxt;
                    fifo_count   <= fifo_count_nxt;
                    rd_ptr       <= rd_ptr_nxt;
                    if (push)
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    if (pop)
                        pop_left <= pop_left - SIZE_WIDTH'(1);
                    if (fifo_count_nxt != CNT_W'(0)) begin
                        empty   <= 1'b0;
                        rd_data <= head_nxt;
                    end else begin
                        empty   <= 1'b1;
                    end
                    // Sum never grows while stalled, so valid stays asserted.
                    mem_req_valid <= (req_left_nxt != '0) &&
                                     (credit_used < (CNT_W+1)'(FIFO_DEPTH));
                    if (last_pop) begin
                        state         <= DONE;
                        rd_done       <= 1'b1;
                        mem_req_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dma_rd_channel.md
Name: dma_rd_channel

Overview:
Host-side responder for the read half of the DMA interface. It serves an AFU that drives rd_addr/rd_size/rd_go and pops cache lines with rd_en. The block converts each transfer into a stream of cache-line read requests toward the memory/HAL side and buffers in-order responses in a first-word-fall-through FIFO. Credit accounting guarantees the FIFO never overflows; rd_done signals that the AFU has consumed every line.

Parameters:
ADDR_WIDTH, 64, virtual byte address width from software
DATA_WIDTH, 512, cache-line width in bits
CL_OFFSET, 6, byte-offset bits per cache line (line address = rd_addr[ADDR_WIDTH-1:CL_OFFSET])
SIZE_WIDTH, 43, transfer-size counter width in cache lines
FIFO_DEPTH, 16, response buffer depth; also the maximum outstanding requests (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset
rd_go  in  1  start pulse; sampled only in IDLE or DONE
rd_addr  in  ADDR_WIDTH  starting byte address, latched on accepted rd_go
rd_size  in  SIZE_WIDTH  number of cache lines, latched on accepted rd_go
rd_en  in  1  AFU pop; effective only when empty==0
empty  out  1  0 = rd_data holds a valid line
rd_data  out  DATA_WIDTH  head-of-FIFO line
rd_done  out  1  high from completion until the next accepted rd_go or reset
mem_req_valid  out  1  read request valid
mem_req_addr  out  ADDR_WIDTH-CL_OFFSET  cache-line address of the request
mem_req_ready  in  1  memory accepts the request this cycle
mem_rsp_valid  in  1  one response line, returned in request order
mem_rsp_data  in  DATA_WIDTH  response data

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. Reset values: empty=1, rd_done=0, mem_req_valid=0, rd_data=0, all counters and FIFO pointers 0, state=IDLE.
- State machine: IDLE, ACTIVE, DONE.
  - IDLE/DONE to ACTIVE on rd_go with rd_size!=0.
  - IDLE/DONE to DONE on rd_go with rd_size==0. rd_done stays or goes high the next cycle; no requests are issued.
  - ACTIVE to DONE on the cycle the last line is popped. rd_done=1 from the next cycle.
  - rd_go during ACTIVE is ignored.
  - An accepted rd_go clears rd_done the next cycle.
- Counters:
  - req_left: lines still to request.
  - pop_left: lines still to be popped.
  - outstanding: accepted requests without a response.
  - fifo_count: lines currently buffered.
- Request issue: mem_req_valid = ACTIVE && req_left!=0 && (outstanding + fifo_count) < FIFO_DEPTH. The credit check is registered and may be conservative by one cycle, but it must never allow overflow.
  - The first request may assert no earlier than the cycle after rd_go.
  - Handshake: a request is accepted on mem_req_valid && mem_req_ready. On acceptance, req_left decrements and mem_req_addr increments by 1, wrapping modulo 2^(ADDR_WIDTH-CL_OFFSET).
  - While valid && !ready, addr and valid are held stable.
- Responses: mem_rsp_valid writes mem_rsp_data into the FIFO and decrements outstanding. Same-cycle request accept and response: outstanding is unchanged.
  - A response arriving while the FIFO is full is an error; the bench asserts it can never happen.
  - Responses received in IDLE/DONE are discarded.
- FIFO: first-word-fall-through.
  - Response written in cycle t: empty=0 and rd_data valid in cycle t+1.
  - Pop in cycle t: the next line (or empty=1) appears in t+1.
  - Simultaneous push and pop: fifo_count is unchanged; order is preserved.
  - rd_en while empty==1 is ignored.
  - rd_data is held when empty==1.
- Reset mid-transfer: everything returns to reset values the next cycle. The memory side is reset with the same rst; no stale responses are accepted.

Test Plan:
1. rd_addr=0x1000, rd_size=4; memory returns data=line address, 3-cycle latency; AFU pops whenever empty==0 -> mem_req_addr sequence 0x40, 0x41, 0x42, 0x43; rd_data 0x40..0x43 in order; rd_done=1 the cycle after the 4th pop.
2. rd_size=0 -> rd_done=1 one cycle after rd_go; mem_req_valid never asserts; a second rd_go with size 2 clears rd_done and completes normally.
3. FIFO_DEPTH=16, rd_size=40, AFU does not pop for 100 cycles -> exactly 16 requests accepted, then mem_req_valid=0. Popping one line enables exactly one more request. All 40 lines arrive in order with no overflow assertion.
4. mem_req_ready toggles randomly (50%) -> mem_req_addr/valid stable while stalled; no line duplicated or skipped (scoreboard over 32 lines).
5. rst asserted after 5 of 10 lines are popped -> next cycle: empty=1, rd_done=0, mem_req_valid=0. A new rd_go (addr 0x0, size 3) completes correctly.
6. rd_go pulsed mid-ACTIVE and rd_en pulsed while empty; rd_addr=0xFFFF_FFFF_FFFF_FFC0, size 2 -> extra go/pop ignored (counters unchanged); request addresses 0x3FF_FFFF_FFFF_FFFF then 0x0 (wrap).
